// File: rtl/excess3_serial_adder.sv
// Multi-digit packed-BCD adder: one Excess-3 digit per clock, LSD first, with a start/busy/done handshake.
// Optional subtract mode (A - B) is enabled by defining EXCESS3_SUBTRACT_EN.
module excess3_serial_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef EXCESS3_SUBTRACT_EN
  input  logic                  sub,
`endif
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum_exc3,
  output logic [4*DIGITS-1:0]   sum_bcd,
  output logic                  carry_out,
  output logic                  error
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           state;
  logic [W-1:0]     a_sr;
  logic [W-1:0]     b_sr;
  logic [IDX_W-1:0] idx;
  logic             carry_q;
`ifdef EXCESS3_SUBTRACT_EN
  logic             sub_q;
`endif

  logic [3:0] ad, bd, ax, bx, dx, db;
  logic [4:0] s;
  logic       dig_err;

  // Single-digit Excess-3 add of the current LSD pair with the rippled carry
  always_comb begin
    ad = a_sr[3:0];
    bd = b_sr[3:0];
    ax = ad + 4'd3;
    bx = bd + 4'd3;
`ifdef EXCESS3_SUBTRACT_EN
    // Inverting an Excess-3 digit gives its nine's complement
    if (sub_q) bx = ~bx;
`endif
    s  = {1'b0, ax} + {1'b0, bx} + {4'd0, carry_q};
    if (s[4]) dx = s[3:0] + 4'd3;
    else      dx = s[3:0] - 4'd3;
    db      = dx - 4'd3;
    dig_err = (ad > 4'd9) || (bd > 4'd9);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      idx       <= '0;
      carry_q   <= 1'b0;
`ifdef EXCESS3_SUBTRACT_EN
      sub_q     <= 1'b0;
`endif
      busy      <= 1'b0;
      done      <= 1'b0;
      sum_exc3  <= '0;
      sum_bcd   <= '0;
      carry_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr    <= a_bcd;
            b_sr    <= b_bcd;
            idx     <= '0;
`ifdef EXCESS3_SUBTRACT_EN
            sub_q   <= sub;
            carry_q <= sub;
`else
            carry_q <= 1'b0;
`endif
            error   <= 1'b0;
            busy    <= 1'b1;
            state   <= S_ADD;
          end
        end
        S_ADD: begin
          sum_exc3[{idx, 2'b00} +: 4] <= dx;
          sum_bcd[{idx, 2'b00} +: 4]  <= db;
          a_sr    <= a_sr >> 4;
          b_sr    <= b_sr >> 4;
          carry_q <= s[4];
          error   <= error | dig_err;
          idx     <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            carry_out <= s[4];
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
